bcpu_gen: RTL and testbench
===========================

BCPU_GEN -- requirements
Module: bcpu_gen

Interface
REQ-001 Parameter DW, 16, data/instruction width; SHALL be >= 16.
REQ-002 Parameter AW, 12, address width; SHALL satisfy AW <= DW-4.
REQ-003 Parameter IO_EN, 1, 1 = I/O and interrupt logic present, 0 = I/O instructions execute as NOP, no interrupts.
REQ-004 clk  in  1  clock, rising-edge active.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 mem_req  out  1  memory transaction request.
REQ-007 mem_we  out  1  1 = write, 0 = read; valid while mem_req = 1.
REQ-008 mem_addr  out  AW  transaction address.
REQ-009 mem_wdata  out  DW  write data.
REQ-010 mem_rdata  in  DW  read data, valid in mem_ack cycle.
REQ-011 mem_ack  in  1  transaction complete.
REQ-012 in_data  in  8  input character.
REQ-013 in_valid  in  1  one-cycle strobe; latches in_data into INPR, sets FGI.
REQ-014 out_data  out  8  OUTR contents.
REQ-015 out_valid  out  1  one-cycle pulse when OUT executes; clears FGO.
REQ-016 out_done  in  1  one-cycle strobe, sets FGO.
REQ-017 halted  out  1  high once HLT executes.

Function
REQ-018 Instruction fields SHALL be: I = IR[DW-1], opcode = IR[DW-2:DW-4], address = IR[AW-1:0]; register-reference/I/O selector bits SHALL be IR[11:0].
REQ-019 Opcodes 0-6 SHALL be AND, ADD, LDA, STA, BUN, BSA, ISZ; opcode 7 with I = 0 SHALL be register-reference; opcode 7 with I = 1 SHALL be I/O.
REQ-020 Memory handshake: mem_req, mem_we, mem_addr and mem_wdata SHALL be held stable from assertion until the cycle mem_ack = 1 is sampled; mem_req SHALL deassert in the following cycle; mem_ack without mem_req SHALL be ignored.
REQ-021 States SHALL be FETCH0 (AR<=PC), FETCH1 (read; IR<=rdata, PC<=PC+1), DECODE (AR<=address), INDIR (read; AR<=rdata[AW-1:0]), one or more EXEC states per opcode, INT0, INT1, HALT.
REQ-022 DECODE SHALL go to INDIR if I = 1 and opcode != 7; otherwise to the opcode's EXEC state.
REQ-023 AND/ADD/LDA SHALL read M[AR] into DR, then update AC in the next cycle; ADD SHALL compute {E,AC} = AC + DR at DW+1 bits.
REQ-024 STA SHALL write AC to M[AR]; BUN SHALL set PC<=AR; BSA SHALL write PC zero-extended to M[AR], then set PC<=AR+1.
REQ-025 ISZ SHALL read DR, increment DR modulo 2^DW, write DR back, and set PC<=PC+1 when the incremented DR = 0.
REQ-026 PC and AR arithmetic SHALL wrap modulo 2^AW.
REQ-027 Register-reference bits 11..0 SHALL be CLA, CLE, CMA, CME, CIR, CIL, INC, SPA, SNA, SZA, SZE, HLT, single cycle; CIR/CIL SHALL rotate through E; SPA SHALL skip if AC[DW-1] = 0 and AC != 0.
REQ-028 I/O bits 11..6 SHALL be INP (AC[7:0]<=INPR, clear FGI), OUT (OUTR<=AC[7:0], clear FGO), SKI, SKO, ION, IOF.
REQ-029 A register-reference or I/O word with zero or more than one selector bit set SHALL execute as NOP.
REQ-030 At each instruction end, if IO_EN, IEN = 1 and (FGI or FGO), the FSM SHALL enter INT0 (AR<=0) and then INT1 (write PC to M[0], PC<=1, IEN<=0), then go to FETCH0; otherwise it SHALL go to FETCH0.
REQ-031 in_valid SHALL overwrite INPR even when FGI = 1; in_valid coincident with INP SHALL leave FGI = 1; out_done coincident with OUT SHALL leave FGO = 1.
REQ-032 In HALT, mem_req SHALL stay 0 and the state SHALL persist until reset; the I/O flags SHALL keep updating.

Reset
REQ-033 On rst low, PC, AR, IR, AC, DR, E, INPR, OUTR and IEN SHALL be 0, FGI SHALL be 0, and FGO SHALL be 1.
REQ-034 On rst low, mem_req, mem_we, out_valid and halted SHALL be 0, and the state SHALL be FETCH0.
REQ-035 Reset during a pending transaction SHALL drop mem_req immediately, with no wait for mem_ack.

Verification
REQ-036 Scenario: M[0]=LDA 10, M[1]=ADD 11, M[2]=HLT, M[10]=FFFF, M[11]=0002, ack latency 0 -> AC = 0001, E = 1, halted = 1.
REQ-037 Scenario: repeat the previous program with random ack latency 0-5 -> identical final state; mem_addr/mem_wdata stable during every wait.
REQ-038 Scenario: ISZ on a location holding FFFF -> memory becomes 0000 and the next instruction is skipped; on 0005 -> memory becomes 0006 and no skip.
REQ-039 Scenario: indirect BSA through M[20] = 30 with PC = 5 -> M[30] = 0006 and PC = 31.
REQ-040 Scenario: ION, then in_valid with in_data = 41 -> M[0] = return PC, PC = 1, IEN = 0; INP there -> AC[7:0] = 41, FGI = 0.
REQ-041 Scenario: a CLA|CMA word -> NOP; rst pulsed during a read wait -> mem_req = 0 within the reset, and the processor restarts at PC = 0.

Source files
------------

// File: rtl/bcpu_gen.sv
// Purpose : accumulator CPU with memory-reference, register-reference and I/O instructions
// Latency : 2+ cycles per memory access (request, then ack); reg-ref/I/O execute in one cycle
// Backpr. : every memory access waits, holding the request stable, until mem_ack is sampled
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   mem_req/we/addr/wdata    request side of the memory handshake (registered)
//   mem_rdata, mem_ack       read data and completion strobe from memory
//   in_data, in_valid        input character strobe (loads INPR, sets FGI)
//   out_data, out_valid      OUTR contents and one-cycle pulse on OUT
//   out_done                 output consumed strobe (sets FGO)
//   halted                   sticky, set once HLT executes
module bcpu_gen #(
  parameter int DW    = 16,  // data/instruction width, >= 16
  parameter int AW    = 12,  // address width, <= DW-4
  parameter int IO_EN = 1    // 0: I/O words are NOPs and interrupts never fire
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_done,
  output logic          halted
);

  localparam bit            IO_ON = (IO_EN != 0);
  localparam logic [AW-1:0] ONE_A = 1;
  localparam logic [DW-1:0] ONE_D = 1;

  typedef enum logic [4:0] {
    S_FETCH0, S_FETCH1, S_DECODE, S_INDIR,
    S_RD, S_ALU, S_ISZ_INC, S_ISZ_WR,
    S_STA, S_BUN, S_BSA_WR, S_BSA_J,
    S_REG, S_IO, S_INT0, S_INT1, S_HALT
  } state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_cmd_t;

  state_t        state, state_nxt, exec_state, end_state;
  logic [AW-1:0] pc, ar;
  logic [DW-1:0] ir, ac, dr;
  logic          e;
  logic [7:0]    inpr, outr;
  logic          ien, fgi, fgo;

  mem_cmd_t      cmd;
  logic          mem_need;
  logic          mem_done;
  logic          ir_ind;
  logic [2:0]    ir_op;
  logic [11:0]   sel;
  logic          ien_eff;
  logic          int_go;
  logic          do_inp, do_out;

  assign ir_ind   = ir[DW-1];
  assign ir_op    = ir[DW-2:DW-4];
  assign sel      = ir[11:0];
  // ack is only meaningful against an outstanding request
  assign mem_done = mem_req & mem_ack;
  assign out_data = outr;

  assign do_inp = IO_ON && (state == S_IO) && (sel == 12'h800);
  assign do_out = IO_ON && (state == S_IO) && (sel == 12'h400);

  // ION/IOF take effect for the interrupt decision at the end of their own instruction
  always_comb begin
    ien_eff = ien;
    if (IO_ON && state == S_IO) begin
      if (sel == 12'h080) ien_eff = 1'b1;
      else if (sel == 12'h040) ien_eff = 1'b0;
    end
  end

  assign int_go = IO_ON && ien_eff && (fgi || fgo);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH0;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    mem_need   = 1'b0;
    cmd        = '0;
    end_state  = int_go ? S_INT0 : S_FETCH0;
    exec_state = S_RD;
    case (ir_op)
      3'd3:    exec_state = S_STA;
      3'd4:    exec_state = S_BUN;
      3'd5:    exec_state = S_BSA_WR;
      3'd7:    exec_state = ir_ind ? S_IO : S_REG;
      default: exec_state = S_RD;  // AND, ADD, LDA, ISZ all start with an operand read
    endcase

    case (state)
      S_FETCH0: state_nxt = S_FETCH1;
      S_FETCH1: begin
        mem_need = 1'b1;
        cmd.addr = ar;
        if (mem_done) state_nxt = S_DECODE;
      end
      S_DECODE: state_nxt = (ir_ind && ir_op != 3'd7) ? S_INDIR : exec_state;
      S_INDIR: begin
        mem_need = 1'b1;
        cmd.addr = ar;
        if (mem_done) state_nxt = exec_state;
      end
      S_RD: begin
        mem_need = 1'b1;
        cmd.addr = ar;
        if (mem_done) state_nxt = (ir_op == 3'd6) ? S_ISZ_INC : S_ALU;
      end
      S_ALU:     state_nxt = end_state;
      S_ISZ_INC: state_nxt = S_ISZ_WR;
      S_ISZ_WR: begin
        mem_need  = 1'b1;
        cmd.we    = 1'b1;
        cmd.addr  = ar;
        cmd.wdata = dr;
        if (mem_done) state_nxt = end_state;
      end
      S_STA: begin
        mem_need  = 1'b1;
        cmd.we    = 1'b1;
        cmd.addr  = ar;
        cmd.wdata = ac;
        if (mem_done) state_nxt = end_state;
      end
      S_BUN: state_nxt = end_state;
      S_BSA_WR: begin
        mem_need  = 1'b1;
        cmd.we    = 1'b1;
        cmd.addr  = ar;
        cmd.wdata = {{(DW-AW){1'b0}}, pc};
        if (mem_done) state_nxt = S_BSA_J;
      end
      S_BSA_J: state_nxt = end_state;
      S_REG:   state_nxt = (sel == 12'h001) ? S_HALT : end_state;
      S_IO:    state_nxt = end_state;
      S_INT0:  state_nxt = S_INT1;
      S_INT1: begin
        mem_need  = 1'b1;
        cmd.we    = 1'b1;
        cmd.addr  = '0;
        cmd.wdata = {{(DW-AW){1'b0}}, pc};
        if (mem_done) state_nxt = S_FETCH0;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= '0;
      ar        <= '0;
      ir        <= '0;
      ac        <= '0;
      dr        <= '0;
      e         <= 1'b0;
      inpr      <= '0;
      outr      <= '0;
      ien       <= 1'b0;
      fgi       <= 1'b0;
      fgo       <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      // request is launched from the registered command and frozen until ack
      if (mem_done) begin
        mem_req <= 1'b0;
      end else if (mem_need && !mem_req) begin
        mem_req   <= 1'b1;
        mem_we    <= cmd.we;
        mem_addr  <= cmd.addr;
        mem_wdata <= cmd.wdata;
      end

      out_valid <= 1'b0;

      case (state)
        S_FETCH0: ar <= pc;
        S_FETCH1: if (mem_done) begin
          ir <= mem_rdata;
          pc <= pc + ONE_A;
        end
        S_DECODE: ar <= ir[AW-1:0];
        S_INDIR:  if (mem_done) ar <= mem_rdata[AW-1:0];
        S_RD:     if (mem_done) dr <= mem_rdata;
        S_ALU: begin
          case (ir_op)
            3'd0:    ac <= ac & dr;
            3'd1:    {e, ac} <= {1'b0, ac} + {1'b0, dr};
            3'd2:    ac <= dr;
            default: ;
          endcase
        end
        S_ISZ_INC: dr <= dr + ONE_D;
        S_ISZ_WR:  if (mem_done && dr == '0) pc <= pc + ONE_A;
        S_BUN:     pc <= ar;
        S_BSA_J:   pc <= ar + ONE_A;
        S_REG: begin
          // exact-match decode: zero or multiple selector bits fall to the NOP default
          case (sel)
            12'h800: ac <= '0;
            12'h400: e  <= 1'b0;
            12'h200: ac <= ~ac;
            12'h100: e  <= ~e;
            12'h080: begin ac <= {e, ac[DW-1:1]}; e <= ac[0];    end
            12'h040: begin ac <= {ac[DW-2:0], e}; e <= ac[DW-1]; end
            12'h020: ac <= ac + ONE_D;
            12'h010: if (!ac[DW-1] && ac != '0) pc <= pc + ONE_A;
            12'h008: if (ac[DW-1])              pc <= pc + ONE_A;
            12'h004: if (ac == '0)              pc <= pc + ONE_A;
            12'h002: if (!e)                    pc <= pc + ONE_A;
            12'h001: halted <= 1'b1;
            default: ;
          endcase
        end
        S_IO: begin
          if (IO_ON) begin
            case (sel)
              12'h800: ac[7:0] <= inpr;
              12'h400: begin outr <= ac[7:0]; out_valid <= 1'b1; end
              12'h200: if (fgi) pc <= pc + ONE_A;
              12'h100: if (fgo) pc <= pc + ONE_A;
              12'h080: ien <= 1'b1;
              12'h040: ien <= 1'b0;
              default: ;
            endcase
          end
        end
        S_INT0: ar <= '0;
        S_INT1: if (mem_done) begin
          pc  <= ONE_A;
          ien <= 1'b0;
        end
        default: ;
      endcase

      // flags keep running in every state, including HALT; a strobe beats a clear
      if (IO_ON) begin
        if (do_inp) fgi <= 1'b0;
        if (in_valid) begin
          inpr <= in_data;
          fgi  <= 1'b1;
        end
        if (do_out)   fgo <= 1'b0;
        if (out_done) fgo <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcpu_gen.sv
// Purpose : directed bench for bcpu_gen with a latency-programmable memory model
// Latency : n/a
// Backpr. : memory model inserts 0..N wait cycles before mem_ack
module tb_bcpu_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack   = 1'b0;
  logic [7:0]  in_data   = '0;
  logic        in_valid  = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_done  = 1'b0;
  logic        halted;

  always #5 clk = ~clk;

  bcpu_gen #(.DW(16), .AW(12), .IO_EN(1)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_done(out_done),
    .halted(halted)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [15:0] mem [0:4095];
  int          wait_cnt = 0, cur_lat = 0, lat_max = 0, lat_force = -1, stab_viol = 0;
  bit          busy = 1'b0;
  logic [11:0] cap_addr;
  logic [15:0] cap_wdata;
  logic        cap_we;

  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (!rst) begin
      busy     = 1'b0;
      wait_cnt = 0;
    end else if (mem_req) begin
      if (!busy) begin
        busy      = 1'b1;
        cap_addr  = mem_addr;
        cap_wdata = mem_wdata;
        cap_we    = mem_we;
        wait_cnt  = 0;
        cur_lat   = (lat_force >= 0) ? lat_force : int'($urandom_range(lat_max, 0));
      end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata || mem_we !== cap_we) begin
        stab_viol++;
      end
      if (wait_cnt >= cur_lat) begin
        mem_ack = 1'b1;
        if (mem_we) mem[mem_addr] = mem_wdata;
        else        mem_rdata     = mem[mem_addr];
        busy = 1'b0;
      end else begin
        wait_cnt++;
      end
    end
  end

  int         out_cnt = 0;
  logic [7:0] out_last = '0;
  always @(negedge clk) if (out_valid) begin
    out_cnt++;
    out_last = out_data;
  end

  task automatic fill_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h7001;  // HLT everywhere bounds stray runs
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_halt(input string nm, input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(nm, halted, 1);
  endtask

  // ---------------- single-instruction vectors ----------------
  // program: 0 LDA 20 / 1 CME or NOP / 2 instr / 3 HLT / 4 HLT
  // final PC is 4 without skip, 5 with skip
  typedef struct {
    logic [15:0] ac0;
    logic        e0;
    logic [15:0] ins;
    logic [15:0] opnd;
    logic [15:0] ac;
    logic        e;
    logic [11:0] pc;
    logic [15:0] m21;
  } vec_t;

  vec_t vecs [25];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            ac0       e0    ins       opnd      ac        e     pc       m21
    vecs[0]  = '{16'hFFFF, 1'b0, 16'h1021, 16'h0002, 16'h0001, 1'b1, 12'h004, 16'h0002}; // ADD carry
    vecs[1]  = '{16'hF0F0, 1'b0, 16'h0021, 16'h3C3C, 16'h3030, 1'b0, 12'h004, 16'h3C3C}; // AND
    vecs[2]  = '{16'h0000, 1'b0, 16'h2021, 16'hABCD, 16'hABCD, 1'b0, 12'h004, 16'hABCD}; // LDA
    vecs[3]  = '{16'h0001, 1'b1, 16'h9022, 16'h0001, 16'h0002, 1'b0, 12'h004, 16'h0001}; // ADD I
    vecs[4]  = '{16'h0000, 1'b0, 16'h6021, 16'hFFFF, 16'h0000, 1'b0, 12'h005, 16'h0000}; // ISZ wrap
    vecs[5]  = '{16'h0000, 1'b0, 16'h6021, 16'h0005, 16'h0000, 1'b0, 12'h004, 16'h0006}; // ISZ
    vecs[6]  = '{16'h1234, 1'b1, 16'h7800, 16'h0000, 16'h0000, 1'b1, 12'h004, 16'h0000}; // CLA
    vecs[7]  = '{16'h1234, 1'b1, 16'h7400, 16'h0000, 16'h1234, 1'b0, 12'h004, 16'h0000}; // CLE
    vecs[8]  = '{16'h00FF, 1'b0, 16'h7200, 16'h0000, 16'hFF00, 1'b0, 12'h004, 16'h0000}; // CMA
    vecs[9]  = '{16'h0000, 1'b0, 16'h7100, 16'h0000, 16'h0000, 1'b1, 12'h004, 16'h0000}; // CME
    vecs[10] = '{16'h0003, 1'b1, 16'h7080, 16'h0000, 16'h8001, 1'b1, 12'h004, 16'h0000}; // CIR
    vecs[11] = '{16'h8001, 1'b0, 16'h7040, 16'h0000, 16'h0002, 1'b1, 12'h004, 16'h0000}; // CIL
    vecs[12] = '{16'hFFFF, 1'b0, 16'h7020, 16'h0000, 16'h0000, 1'b0, 12'h004, 16'h0000}; // INC
    vecs[13] = '{16'h0005, 1'b0, 16'h7010, 16'h0000, 16'h0005, 1'b0, 12'h005, 16'h0000}; // SPA +
    vecs[14] = '{16'h0000, 1'b0, 16'h7010, 16'h0000, 16'h0000, 1'b0, 12'h004, 16'h0000}; // SPA 0
    vecs[15] = '{16'h8000, 1'b0, 16'h7010, 16'h0000, 16'h8000, 1'b0, 12'h004, 16'h0000}; // SPA -
    vecs[16] = '{16'h8000, 1'b0, 16'h7008, 16'h0000, 16'h8000, 1'b0, 12'h005, 16'h0000}; // SNA
    vecs[17] = '{16'h0000, 1'b0, 16'h7004, 16'h0000, 16'h0000, 1'b0, 12'h005, 16'h0000}; // SZA
    vecs[18] = '{16'h0001, 1'b0, 16'h7004, 16'h0000, 16'h0001, 1'b0, 12'h004, 16'h0000}; // SZA no
    vecs[19] = '{16'h0000, 1'b0, 16'h7002, 16'h0000, 16'h0000, 1'b0, 12'h005, 16'h0000}; // SZE
    vecs[20] = '{16'h0000, 1'b1, 16'h7002, 16'h0000, 16'h0000, 1'b1, 12'h004, 16'h0000}; // SZE no
    vecs[21] = '{16'h1234, 1'b0, 16'h7A00, 16'h0000, 16'h1234, 1'b0, 12'h004, 16'h0000}; // CLA|CMA
    vecs[22] = '{16'h1234, 1'b0, 16'hF0C0, 16'h0000, 16'h1234, 1'b0, 12'h004, 16'h0000}; // ION|IOF
    vecs[23] = '{16'h5A5A, 1'b0, 16'h3021, 16'h0000, 16'h5A5A, 1'b0, 12'h004, 16'h5A5A}; // STA
    vecs[24] = '{16'h0000, 1'b0, 16'h4004, 16'h0000, 16'h0000, 1'b0, 12'h005, 16'h0000}; // BUN

    // ---------------- reset state ----------------
    #3 rst = 1'b0;
    @(negedge clk);
    check("rst_mem_req",   mem_req,   0);
    check("rst_mem_we",    mem_we,    0);
    check("rst_out_valid", out_valid, 0);
    check("rst_halted",    halted,    0);
    check("rst_pc",        dut.pc,    0);
    check("rst_ac",        dut.ac,    0);
    check("rst_fgi",       dut.fgi,   0);
    check("rst_fgo",       dut.fgo,   1);
    check("rst_ien",       dut.ien,   0);
    check("rst_state",     dut.state, 0);
    rst = 1'b1;

    // ---------------- table ----------------
    lat_max = 0;
    for (int v = 0; v < 25; v++) begin
      fill_mem();
      mem[0]     = 16'h2020;
      mem[1]     = vecs[v].e0 ? 16'h7100 : 16'h7000;
      mem[2]     = vecs[v].ins;
      mem['h20]  = vecs[v].ac0;
      mem['h21]  = vecs[v].opnd;
      mem['h22]  = 16'h0021;
      do_reset();
      run_halt($sformatf("v%0d_halt", v), 400);
      check($sformatf("v%0d_ac", v),  dut.ac,    vecs[v].ac);
      check($sformatf("v%0d_e", v),   dut.e,     vecs[v].e);
      check($sformatf("v%0d_pc", v),  dut.pc,    vecs[v].pc);
      check($sformatf("v%0d_m21", v), mem['h21], vecs[v].m21);
    end

    // ---------------- LDA/ADD/HLT, zero then random ack latency ----------------
    stab_viol = 0;
    for (int r = 0; r < 2; r++) begin
      lat_max = (r == 0) ? 0 : 5;
      for (int k = 0; k < 3; k++) begin
        fill_mem();
        mem[0]     = 16'h2010;
        mem[1]     = 16'h1011;
        mem['h10]  = 16'hFFFF;
        mem['h11]  = 16'h0002;
        do_reset();
        run_halt($sformatf("prog_r%0d_halt", r), 600);
        check($sformatf("prog_r%0d_ac", r), dut.ac, 16'h0001);
        check($sformatf("prog_r%0d_e", r),  dut.e,  1);
      end
    end
    check("handshake_stable", stab_viol, 0);

    // HALT persists with no memory traffic, flags still track strobes
    begin
      int reqs;
      reqs = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (mem_req) reqs++;
      end
      check("halt_no_req", reqs, 0);
      in_data  = 8'h5C;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("halt_fgi_set", dut.fgi, 1);
      check("halt_inpr",    dut.inpr, 8'h5C);
      check("halt_state",   halted, 1);
    end

    // ---------------- indirect BSA from PC=5 ----------------
    lat_max = 2;
    fill_mem();
    mem[0]    = 16'h4005;
    mem[5]    = 16'hD020;
    mem['h20] = 16'h0030;
    mem['h30] = 16'h0000;
    do_reset();
    run_halt("bsa_halt", 400);
    check("bsa_ret",   mem['h30], 16'h0006);
    check("bsa_pc",    dut.pc,    12'h032);

    // ---------------- interrupt on input ----------------
    lat_max = 1;
    fill_mem();
    mem[0]    = 16'h4010;  // BUN 10
    mem[1]    = 16'hF800;  // ISR: INP
    mem[2]    = 16'h7001;  // HLT
    mem['h10] = 16'h2030;  // LDA 30
    mem['h11] = 16'hF400;  // OUT (clears FGO)
    mem['h12] = 16'hF080;  // ION
    mem['h13] = 16'h4013;  // BUN 13 (spin)
    mem['h30] = 16'h0055;
    out_cnt   = 0;
    do_reset();
    repeat (80) @(negedge clk);
    check("int_ien_on",   dut.ien, 1);
    check("int_not_yet",  mem[0],  16'h4010);
    check("int_out_cnt",  out_cnt, 1);
    check("int_out_data", out_last, 8'h55);
    check("int_fgo_clr",  dut.fgo, 0);
    in_data  = 8'h41;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    run_halt("int_halt", 400);
    check("int_ret_pc", mem[0],  16'h0013);
    check("int_ien",    dut.ien, 0);
    check("int_ac",     dut.ac,  16'h0041);
    check("int_fgi",    dut.fgi, 0);
    check("int_pc",     dut.pc,  12'h003);

    // ---------------- reset during a read wait ----------------
    lat_force = 30;
    fill_mem();
    do_reset();
    begin
      int n;
      n = 0;
      while (!mem_req && n < 20) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      check("rw_req_held", mem_req, 1);
      rst = 1'b0;
      #1;
      check("rw_req_drop", mem_req, 0);
      @(negedge clk);
      check("rw_pc_rst", dut.pc, 0);
      lat_force = -1;
      lat_max   = 0;
      rst = 1'b1;
      n = 0;
      while (!mem_req && n < 20) begin @(negedge clk); n++; end
      check("rw_restart_req",  mem_req,  1);
      check("rw_restart_addr", mem_addr, 12'h000);
      check("rw_restart_we",   mem_we,   0);
      run_halt("rw_halt", 200);
      check("rw_pc", dut.pc, 12'h001);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
